// File: rtl/aes_block_serializer_pkg.sv
// Shared types and helpers for the AES ciphertext block serializer.
package aes_block_serializer_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // Width of a beat counter for a given beat size; never narrower than one bit.
  function automatic int beat_cnt_w(input int out_w);
    int nbeats;
    nbeats = AES_BLOCK_W / out_w;
    if (nbeats > 1) begin
      return $clog2(nbeats);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/aes_block_serializer_chk.sv
// Simulation-only property checks for the block serializer output stream.
module aes_block_serializer_chk
  import aes_block_serializer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OUT_W = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             rst,
  input logic             out_valid,
  input logic             out_ready,
  input logic [OUT_W-1:0] out_data,
  input logic             out_last,
  input logic [CW-1:0]    fifo_level
);

  if ((AES_BLOCK_W % OUT_W) != 0) begin : g_bad_out_w
    $error("OUT_W must divide the AES block width");
  end

  a_level_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_level <= CW'(DEPTH));

  a_hold_stall: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: rtl/aes_block_serializer_fifo.sv
// Block FIFO of DEPTH ciphertext blocks; a push into a full FIFO is taken only alongside a pop.
module aes_block_fifo
  import aes_block_serializer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  aes_block_t    wdata,
  output aes_block_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  aes_block_t    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          wr_en_s;

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == CW'(0));
  assign wr_en_s = push && (!full || pop);
  assign head    = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Block storage; contents are left alone by reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      case ({wr_en_s, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/aes_block_serializer.sv
// Serializes 128-bit AES blocks into OUT_W-bit valid/ready beats through a block FIFO.
module aes_block_serializer
  import aes_block_serializer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  aes_block_t       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [CW-1:0]    fifo_level,
  output logic             overflow
);

  localparam int NBEATS = AES_BLOCK_W / OUT_W;
  localparam int BCW    = beat_cnt_w(OUT_W);

  aes_block_t     head_s;
  logic           full_s;
  logic           empty_s;
  logic [BCW-1:0] beat_cnt_r;
  logic [BCW-1:0] sel_s;
  logic           last_beat_s;
  logic           xfer_s;
  logic           pop_s;
  logic           overflow_r;

  aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop_s),
    .wdata (in_data),
    .head  (head_s),
    .count (fifo_level),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid   = !empty_s;
  assign last_beat_s = (beat_cnt_r == BCW'(NBEATS - 1));
  assign out_last    = out_valid && last_beat_s;
  assign xfer_s      = out_valid && out_ready;
  assign pop_s       = xfer_s && last_beat_s;
  assign overflow    = overflow_r;

  // Map beat order onto the slice index inside the head block
  always_comb begin
    sel_s = beat_cnt_r;
    if (MSB_FIRST != 0) begin
      sel_s = BCW'(NBEATS - 1) - beat_cnt_r;
    end else begin
      sel_s = beat_cnt_r;
    end
  end

  assign out_data = head_s[int'(sel_s) * OUT_W +: OUT_W];

  // Beat position within the head block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r <= '0;
    end else if (xfer_s) begin
      if (last_beat_s) begin
        beat_cnt_r <= '0;
      end else begin
        beat_cnt_r <= beat_cnt_r + BCW'(1);
      end
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Sticky drop flag: a block arrives full with no pop to make room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (in_valid && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  aes_block_serializer_chk #(.DEPTH(DEPTH), .OUT_W(OUT_W)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_level (fifo_level)
  );

endmodule
